// File: rtl/pin_keypad.sv
// pin_keypad: two-digit BCD PIN entry stage with clear, reject and inactivity timeout.
// Optional PIN_KEYPAD_SHIFT_EN: a third digit shifts the buffer instead of being rejected.
module pin_keypad #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] Key,
  input  logic       Key_press,
  output logic [7:0] Pin,
  output logic       enterPin,
  output logic [1:0] Digit_count,
  output logic       Error
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
  state_t           r_state;
  logic [7:0]       r_buf;
  logic [CNT_W-1:0] r_timer;
  logic             r_press_q;
  logic             w_event;
  logic             w_digit;
  logic             w_expire;
  assign w_event     = Key_press & ~r_press_q;
  assign w_digit     = Key <= 4'd9;
  assign w_expire    = (r_state != EMPTY) && (r_timer == CNT_W'(TIMEOUT_CYCLES - 1));
  assign Digit_count = r_state;
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state   <= EMPTY;
      r_buf     <= 8'h00;
      r_timer   <= '0;
      r_press_q <= 1'b0;
      Pin       <= 8'h00;
      enterPin  <= 1'b0;
      Error     <= 1'b0;
    end else begin
      r_press_q <= Key_press;
      enterPin  <= 1'b0;
      Error     <= 1'b0;
      r_timer   <= (w_event || r_state == EMPTY || w_expire) ? '0 : r_timer + CNT_W'(1);
      if (w_event) begin
        if (w_digit) begin
          case (r_state)
            EMPTY: begin
              r_buf   <= {Key, 4'h0};
              r_state <= ONE;
            end
            ONE: begin
              r_buf   <= {r_buf[7:4], Key};
              r_state <= TWO;
            end
            default: begin
`ifdef PIN_KEYPAD_SHIFT_EN
              r_buf <= {r_buf[3:0], Key};
`else
              Error <= 1'b1;
`endif
            end
          endcase
        end else if (Key == 4'hA) begin
          r_buf   <= 8'h00;
          r_state <= EMPTY;
        end else if (Key == 4'hB) begin
          // only a full two-digit entry reaches the controller
          if (r_state == TWO) begin
            Pin      <= r_buf;
            enterPin <= 1'b1;
          end else begin
            Error <= 1'b1;
          end
          r_buf   <= 8'h00;
          r_state <= EMPTY;
        end else begin
          Error <= 1'b1;
        end
      end else if (w_expire) begin
        r_buf   <= 8'h00;
        r_state <= EMPTY;
        Error   <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pin_keypad.sv
// tb_pin_keypad: scoreboard bench for pin_keypad; expected outputs come from a behavioural model.
module tb_pin_keypad;
  localparam int TMO = 16;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key = 4'h0;
  logic       kp = 1'b0;
  logic [7:0] Pin;
  logic       enterPin;
  logic [1:0] Digit_count;
  logic       Error;
  typedef struct packed {
    logic [7:0] pin;
    logic       ent;
    logic       err;
    logic [1:0] cnt;
  } exp_t;
  exp_t       q[$];
  int         errors = 0;
  int         checks = 0;
  logic [1:0] m_cnt = 2'd0;
  logic [7:0] m_buf = 8'h00;
  logic [7:0] m_pin = 8'h00;

  pin_keypad #(.TIMEOUT_CYCLES(TMO), .CNT_W(16)) dut (
    .Clk(clk), .Reset(rst_n), .Key(key), .Key_press(kp),
    .Pin(Pin), .enterPin(enterPin), .Digit_count(Digit_count), .Error(Error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [3:0] k);
    exp_t e;
    e.ent = 1'b0;
    e.err = 1'b0;
    if (k <= 4'd9) begin
      if (m_cnt == 2'd0) begin
        m_buf = {k, 4'h0};
        m_cnt = 2'd1;
      end else if (m_cnt == 2'd1) begin
        m_buf[3:0] = k;
        m_cnt = 2'd2;
      end else begin
`ifdef PIN_KEYPAD_SHIFT_EN
        m_buf = {m_buf[3:0], k};
`else
        e.err = 1'b1;
`endif
      end
    end else if (k == 4'hA) begin
      m_buf = 8'h00;
      m_cnt = 2'd0;
    end else if (k == 4'hB) begin
      if (m_cnt == 2'd2) begin
        m_pin = m_buf;
        e.ent = 1'b1;
      end else e.err = 1'b1;
      m_buf = 8'h00;
      m_cnt = 2'd0;
    end else e.err = 1'b1;
    e.pin = m_pin;
    e.cnt = m_cnt;
    q.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      check({tag, "_queue_empty"}, 1, 0);
      return;
    end
    e = q.pop_front();
    check({tag, "_pin"}, Pin, e.pin);
    check({tag, "_enter"}, enterPin, e.ent);
    check({tag, "_error"}, Error, e.err);
    check({tag, "_count"}, Digit_count, e.cnt);
  endtask

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key = k;
    kp  = 1'b1;
    model(k);
    @(posedge clk);
    #1 pop_check("press");
    @(negedge clk);
    kp = 1'b0;
    @(posedge clk);
    #1 check("strobe_end", {enterPin, Error}, 0);
  endtask

  always @(negedge clk) if (rst_n) check("excl", enterPin & Error, 0);

  initial begin
    #1;
    check("rst_pin", Pin, 8'h00);
    check("rst_enter", enterPin, 0);
    check("rst_count", Digit_count, 0);
    check("rst_error", Error, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    press(4'h1); press(4'h0); press(4'hB);
    press(4'h9); press(4'hB);
    press(4'h4); press(4'hE); press(4'h2); press(4'hB);
    press(4'h7);
    repeat (TMO - 2) @(posedge clk);
    #1 check("tmo_early", Error, 0);
    @(posedge clk);
    #1 check("tmo_error", Error, 1);
    check("tmo_count", Digit_count, 0);
    m_cnt = 2'd0;
    m_buf = 8'h00;
    press(4'hB);
    press(4'h3); press(4'h5); press(4'h6); press(4'hB);
    press(4'h6); press(4'hA); press(4'hB);
    @(negedge clk);
    key = 4'h8;
    kp  = 1'b1;
    model(4'h8);
    @(posedge clk);
    #1 pop_check("hold");
    repeat (9) begin
      @(posedge clk);
      #1 check("hold_count", Digit_count, 1);
      check("hold_error", Error, 0);
    end
    #2 rst_n = 1'b0;
    #1 check("arst_count", Digit_count, 0);
    check("arst_pin", Pin, 8'h00);
    check("arst_enter", enterPin, 0);
    check("arst_error", Error, 0);
    kp = 1'b0;
    m_cnt = 2'd0;
    m_buf = 8'h00;
    m_pin = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    press(4'h2); press(4'h9);
    @(negedge clk);
    key = 4'hB;
    kp  = 1'b1;
    model(4'hB);
    @(posedge clk);
    #1 pop_check("commit");
    #1 rst_n = 1'b0;
    #1 check("arst_strobe", enterPin, 0);
    check("arst_pin2", Pin, 8'h00);
    kp = 1'b0;
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pin_keypad.md
Name: pin_keypad

Overview:
- Upstream entry stage for the gate controller. Collects key presses from a 4-bit encoded keypad and assembles a two-digit BCD PIN.
- Presents the PIN on Pin[7:0] together with a one-cycle enterPin strobe. These feed the controller's Pin and enterPin inputs directly.
- Handles clear, short-entry rejection, invalid codes and inactivity timeout, so the controller only ever sees complete 2-digit entries.

Parameters:
- TIMEOUT_CYCLES, 64: idle cycles with a partial entry before the buffer is discarded. Legal range 2..65535.
- CNT_W, 16: width of the inactivity counter. Must hold TIMEOUT_CYCLES.

Ports:
- Clk  in  1  system clock; all state updates on its rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Key  in  4  key code. 0x0-0x9 are digits, 0xA is CLEAR, 0xB is ENTER, 0xC-0xF are invalid. Sampled on the press edge.
- Key_press  in  1  level, high while a key is held. Synchronous to Clk.
- Pin  out  8  committed PIN, {first digit, second digit} in BCD. Changes only on commit.
- enterPin  out  1  one-cycle strobe; Pin is valid in the same cycle.
- Digit_count  out  2  digits currently buffered (0, 1 or 2).
- Error  out  1  one-cycle pulse on any rejected action.

Behaviour:
- Reset values (Reset low, asynchronous):
  - Pin = 8'h00, enterPin = 0, Digit_count = 0, Error = 0.
  - State = EMPTY, buffer = 8'h00, timer = 0, press-edge register = 0.
- Press detection:
  - Key_press is registered each cycle. A press event is Key_press = 1 with previous value 0.
  - Key is captured in the event cycle. Holding the key produces no further events.
  - Release is not required before a different code is pressed, but that does not generate an event.
- Latency: every output effect of an event becomes visible on the next Clk edge (1-cycle latency).
- FSM states: EMPTY, ONE, TWO.
  - EMPTY + digit d: buffer[7:4] = d, go to ONE.
  - ONE + digit d: buffer[3:0] = d, go to TWO.
  - TWO + digit: ignored, Error pulses, state unchanged. See the optional feature for the alternative.
  - TWO + ENTER: Pin = buffer, enterPin = 1 for exactly one cycle, buffer = 0, go to EMPTY.
  - EMPTY or ONE + ENTER: no commit, Error pulses, buffer = 0, go to EMPTY. Pin keeps its old value.
  - Any state + CLEAR: buffer = 0, go to EMPTY, no Error.
  - Any state + code 0xC-0xF: Error pulses, state and buffer unchanged.
- Digit_count tracks the state: EMPTY = 0, ONE = 1, TWO = 2.
- Inactivity timer:
  - Resets to 0 on every press event and whenever the state is EMPTY.
  - Increments each cycle in ONE or TWO.
  - When it reaches TIMEOUT_CYCLES-1 with no event that cycle: buffer = 0, go to EMPTY, Error pulses.
  - An event in the same cycle as expiry takes priority and the timeout is dropped.
- enterPin and Error are never high in the same cycle.
- Pin holds its value indefinitely between commits.
- Reset asserted mid-entry discards the buffer. Any enterPin already asserted is cleared immediately (asynchronous).

Optional Feature:
- Macro: PIN_KEYPAD_SHIFT_EN.
- Defined: a digit pressed in TWO shifts the buffer, i.e. buffer = {buffer[3:0], d}. State stays TWO, no Error. The last two digits typed are the ones committed.
- Not defined: a digit in TWO is ignored and Error pulses, as described in Behaviour.

Test Plan:
- Reset low 2 cycles, then high; press 1, press 0, press ENTER -> one cycle after the ENTER edge, Pin = 8'h10 and enterPin = 1 for exactly 1 cycle; Digit_count sequence 1, 2, 0.
- Press 9 then ENTER -> Error pulse 1 cycle, no enterPin, Pin keeps 8'h10, Digit_count = 0.
- Press 4, press 0xE, press 2, ENTER -> Error pulse on 0xE; Pin = 8'h42 with enterPin.
- Press 7, then idle TIMEOUT_CYCLES cycles -> Error pulse, Digit_count = 0; a following ENTER gives Error, not a commit.
- Press 3, 5, 6, ENTER -> without macro: Error on 6, Pin = 8'h35. With PIN_KEYPAD_SHIFT_EN: no Error, Pin = 8'h56.
- Hold Key_press high 10 cycles on digit 8 -> Digit_count = 1 only. Assert Reset mid-hold -> all outputs 0 asynchronously.
